// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
// The optional BRU_PERF_EN macro (retire/mispredict counters) is handled in the top.
package bru_pkg;

    localparam int BRU_LINK_OFFSET = 4;
    localparam int BRU_XLEN        = 32;
    localparam int BRU_TAG_W       = 5;

    // funct3 encoding; code 3 never resolves taken
    typedef enum logic [2:0] {
        BRU_BEQ    = 3'd0,
        BRU_BNE    = 3'd1,
        BRU_UNCOND = 3'd2,
        BRU_RSVD   = 3'd3,
        BRU_BLT    = 3'd4,
        BRU_BGE    = 3'd5,
        BRU_BLTU   = 3'd6,
        BRU_BGEU   = 3'd7
    } bru_func_t;

    // Stage-1 record at the default widths; the unit re-declares the same
    // field list at its own XLEN/TAG_W since packages cannot be parametrised.
    typedef struct packed {
        logic                 valid;
        logic                 taken;
        logic [BRU_XLEN-1:0]  target;
        logic [BRU_XLEN-1:0]  link;
        logic                 pred_taken;
        logic [BRU_XLEN-1:0]  pred_target;
        logic [BRU_TAG_W-1:0] tag;
    } bru_stage_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Issue/result bundle of the branch resolve unit.
// An op transfers when in_valid & in_ready at a clock edge; a result retires when
// out_valid & out_ready. A held valid keeps its payload stable until it transfers.
interface branch_resolve_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_func;
    logic             in_is_jalr;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic [TAG_W-1:0] in_tag;
    logic             squash;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_next_pc;
    logic [XLEN-1:0]  out_link;
    logic             out_mispredict;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_func, in_is_jalr, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, in_tag, squash, out_ready,
        input  in_ready, out_valid, out_taken, out_next_pc, out_link,
               out_mispredict, out_tag
    );

    modport slave (
        input  in_valid, in_func, in_is_jalr, in_rs1, in_rs2, in_pc, in_imm,
               in_pred_taken, in_pred_target, in_tag, squash, out_ready,
        output in_ready, out_valid, out_taken, out_next_pc, out_link,
               out_mispredict, out_tag
    );
endinterface

// File: rtl/bru_cond_eval.sv
// Combinational RISC-V branch condition evaluation for XLEN-wide operands.
module bru_cond_eval
    import bru_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  bru_func_t       func,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);
    logic eq;
    logic lt_s;
    logic lt_u;

    always_comb begin
        eq    = (rs1 == rs2);
        lt_s  = ($signed(rs1) < $signed(rs2));
        lt_u  = (rs1 < rs2);
        taken = 1'b0;
        case (func)
            BRU_BEQ:    taken = eq;
            BRU_BNE:    taken = !eq;
            BRU_UNCOND: taken = 1'b1;
            BRU_BLT:    taken = lt_s;
            BRU_BGE:    taken = !lt_s;
            BRU_BLTU:   taken = lt_u;
            BRU_BGEU:   taken = !lt_u;
            default:    taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch/jump resolution (DEPTH 1 or 2) with valid/ready and squash.
// Define BRU_PERF_EN to add saturating retire and mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    branch_resolve_unit_if.slave bus
`ifdef BRU_PERF_EN
    ,
    output logic [31:0]          perf_resolved,
    output logic [31:0]          perf_mispredict
`endif
);

    typedef struct packed {
        logic             valid;
        logic             taken;
        logic [XLEN-1:0]  target;
        logic [XLEN-1:0]  link;
        logic             pred_taken;
        logic [XLEN-1:0]  pred_target;
        logic [TAG_W-1:0] tag;
    } stage_t;

    stage_t          s1;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            cond_taken;
    logic            down_adv;
    logic            s1_adv;
    logic [XLEN-1:0] s1_next_pc;
    logic            s1_mispredict;

    bru_cond_eval #(.XLEN(XLEN)) u_cond (
        .func  (bru_func_t'(bus.in_func)),
        .rs1   (bus.in_rs1),
        .rs2   (bus.in_rs2),
        .taken (cond_taken)
    );

    // JALR target drops bit 0; every add wraps modulo 2^XLEN
    always_comb begin
        base   = bus.in_is_jalr ? bus.in_rs1 : bus.in_pc;
        sum    = base + bus.in_imm;
        target = bus.in_is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
        link   = bus.in_pc + XLEN'(BRU_LINK_OFFSET);
    end

    assign s1_adv       = !s1.valid | down_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
        end else if (bus.squash) begin
            s1.valid <= 1'b0;
        end else if (s1_adv) begin
            s1.valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1.taken       <= cond_taken;
                s1.target      <= target;
                s1.link        <= link;
                s1.pred_taken  <= bus.in_pred_taken;
                s1.pred_target <= bus.in_pred_target;
                s1.tag         <= bus.in_tag;
            end
        end
    end

    // The predicted target only matters when the op actually resolves taken
    always_comb begin
        s1_next_pc    = s1.taken ? s1.target : s1.link;
        s1_mispredict = (s1.taken != s1.pred_taken) |
                        (s1.taken & (s1.target != s1.pred_target));
    end

    generate
        if (DEPTH == 2) begin : g_two
            logic             s2_valid;
            logic             s2_taken;
            logic             s2_mispredict;
            logic [XLEN-1:0]  s2_next_pc;
            logic [XLEN-1:0]  s2_link;
            logic [TAG_W-1:0] s2_tag;

            assign down_adv = !s2_valid | bus.out_ready;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    s2_valid      <= 1'b0;
                    s2_taken      <= 1'b0;
                    s2_mispredict <= 1'b0;
                    s2_next_pc    <= '0;
                    s2_link       <= '0;
                    s2_tag        <= '0;
                end else if (bus.squash) begin
                    s2_valid <= 1'b0;
                end else if (down_adv) begin
                    s2_valid <= s1.valid;
                    if (s1.valid) begin
                        s2_taken      <= s1.taken;
                        s2_mispredict <= s1_mispredict;
                        s2_next_pc    <= s1_next_pc;
                        s2_link       <= s1.link;
                        s2_tag        <= s1.tag;
                    end
                end
            end

            assign bus.out_valid      = s2_valid;
            assign bus.out_taken      = s2_taken;
            assign bus.out_next_pc    = s2_next_pc;
            assign bus.out_link       = s2_link;
            assign bus.out_mispredict = s2_mispredict;
            assign bus.out_tag        = s2_tag;
        end else if (DEPTH == 1) begin : g_one
            assign down_adv           = bus.out_ready;
            assign bus.out_valid      = s1.valid;
            assign bus.out_taken      = s1.taken;
            assign bus.out_next_pc    = s1_next_pc;
            assign bus.out_link       = s1.link;
            assign bus.out_mispredict = s1_mispredict;
            assign bus.out_tag        = s1.tag;
        end else begin : g_bad
            $error("branch_resolve_unit: DEPTH must be 1 or 2");
            assign down_adv           = 1'b0;
            assign bus.out_valid      = 1'b0;
            assign bus.out_taken      = 1'b0;
            assign bus.out_next_pc    = '0;
            assign bus.out_link       = '0;
            assign bus.out_mispredict = 1'b0;
            assign bus.out_tag        = '0;
        end
    endgenerate

`ifdef BRU_PERF_EN
    logic retire;
    assign retire = bus.out_valid & bus.out_ready;

    // Counters saturate and deliberately ignore squash
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_resolved   <= '0;
            perf_mispredict <= '0;
        end else if (retire) begin
            if (perf_resolved != '1) perf_resolved <= perf_resolved + 32'd1;
            if (bus.out_mispredict && (perf_mispredict != '1))
                perf_mispredict <= perf_mispredict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors, stall, squash, async reset.
// Checks the BRU_PERF_EN counters when that macro is defined.
module tb_branch_resolve_unit;
    import bru_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic             taken;
        logic [XLEN-1:0]  next_pc;
        logic [XLEN-1:0]  link;
        logic             mis;
        logic [TAG_W-1:0] tag;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    branch_resolve_unit_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
`ifdef BRU_PERF_EN
    logic [31:0] perf_resolved;
    logic [31:0] perf_mispredict;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .bus             (bus)
`ifdef BRU_PERF_EN
        ,
        .perf_resolved   (perf_resolved),
        .perf_mispredict (perf_mispredict)
`endif
    );

    logic [EXP_W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retired result is popped and compared in order
    always @(negedge clock) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got tag 0x%0h expected none", bus.out_tag);
            end else begin
                exp_t e;
                e = exp_t'(exp_q.pop_front());
                chk("out_tag", 64'(bus.out_tag), 64'(e.tag));
                chk("out_taken", 64'(bus.out_taken), 64'(e.taken));
                chk("out_next_pc", 64'(bus.out_next_pc), 64'(e.next_pc));
                chk("out_link", 64'(bus.out_link), 64'(e.link));
                chk("out_mispredict", 64'(bus.out_mispredict), 64'(e.mis));
            end
        end
    end

    // Caller sits just after a posedge; returns just after the accepting posedge
    task automatic send(input logic [2:0] func, input logic jalr,
                        input logic [31:0] rs1, input logic [31:0] rs2,
                        input logic [31:0] pc, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptgt, input logic [4:0] tag,
                        input logic e_taken, input logic [31:0] e_npc, input logic e_mis);
        bit   ok;
        exp_t e;
        ok = 1'b0;
        bus.in_valid       = 1'b1;
        bus.in_func        = func;
        bus.in_is_jalr     = jalr;
        bus.in_rs1         = rs1;
        bus.in_rs2         = rs2;
        bus.in_pc          = pc;
        bus.in_imm         = imm;
        bus.in_pred_taken  = pt;
        bus.in_pred_target = ptgt;
        bus.in_tag         = tag;
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                e.taken   = e_taken;
                e.next_pc = e_npc;
                e.link    = pc + 32'd4;
                e.mis     = e_mis;
                e.tag     = tag;
                exp_q.push_back(EXP_W'(e));
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tag %0d never accepted", tag);
        end
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            if (bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0) break;
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
    endtask

    // Five ops, two of which mispredict
    task automatic send_perf_set();
        send(3'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd21, 1'b1, 32'h120, 1'b1);
        send(3'd6, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd22, 1'b0, 32'h104, 1'b0);
        send(3'd2, 1'b1, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2006, 5'd23, 1'b1, 32'h2006, 1'b0);
        send(3'd2, 1'b1, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2008, 5'd24, 1'b1, 32'h2006, 1'b1);
        send(3'd0, 1'b0, 32'h5, 32'h5, 32'h400, 32'hFFFF_FFF0, 1'b1, 32'h3F0, 5'd25, 1'b1, 32'h3F0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        bus.in_valid       = 1'b0;
        bus.in_func        = 3'd0;
        bus.in_is_jalr     = 1'b0;
        bus.in_rs1         = '0;
        bus.in_rs2         = '0;
        bus.in_pc          = '0;
        bus.in_imm         = '0;
        bus.in_pred_taken  = 1'b0;
        bus.in_pred_target = '0;
        bus.in_tag         = '0;
        bus.squash         = 1'b0;
        bus.out_ready      = 1'b1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_taken", 64'(bus.out_taken), 64'd0);
        chk("rst_out_next_pc", 64'(bus.out_next_pc), 64'd0);
        chk("rst_out_link", 64'(bus.out_link), 64'd0);
        chk("rst_out_mispredict", 64'(bus.out_mispredict), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        @(posedge clock);
        #1;

        // First op into an empty pipe: measure latency
        send(3'd4, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h0, 5'd1, 1'b1, 32'h120, 1'b1);
        lat = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.out_valid) break;
            lat++;
        end
        chk("latency", 64'(lat), 64'(DEPTH));
        @(posedge clock);
        #1;

        // Directed vectors, back to back
        send(3'd6, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 32'h5555_5554, 5'd2, 1'b0, 32'h104, 1'b0);
        send(3'd2, 1'b1, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2006, 5'd3, 1'b1, 32'h2006, 1'b0);
        send(3'd2, 1'b1, 32'h2003, 32'h0, 32'h300, 32'h4, 1'b1, 32'h2008, 5'd4, 1'b1, 32'h2006, 1'b1);
        send(3'd0, 1'b0, 32'h5, 32'h5, 32'h400, 32'hFFFF_FFF0, 1'b1, 32'h3F0, 5'd5, 1'b1, 32'h3F0, 1'b0);
        send(3'd1, 1'b0, 32'h5, 32'h5, 32'h500, 32'h10, 1'b1, 32'h510, 5'd6, 1'b0, 32'h504, 1'b1);
        send(3'd5, 1'b0, 32'h8000_0000, 32'h0, 32'h600, 32'h8, 1'b0, 32'h0, 5'd7, 1'b0, 32'h604, 1'b0);
        send(3'd7, 1'b0, 32'h8000_0000, 32'h0, 32'h600, 32'h8, 1'b0, 32'h0, 5'd8, 1'b1, 32'h608, 1'b1);
        send(3'd3, 1'b0, 32'h0, 32'h0, 32'h700, 32'h40, 1'b1, 32'h740, 5'd9, 1'b0, 32'h704, 1'b1);
        send(3'd2, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 5'd10, 1'b1, 32'h10, 1'b0);
        send(3'd4, 1'b0, 32'h1, 32'h1, 32'h800, 32'h8, 1'b0, 32'hDEAD_0000, 5'd11, 1'b0, 32'h804, 1'b0);
        send(3'd0, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h10, 1'b0, 32'h0, 5'd12, 1'b0, 32'h0, 1'b0);
        send(3'd6, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h900, 32'hC, 1'b1, 32'h90C, 5'd13, 1'b1, 32'h90C, 1'b0);
        send(3'd5, 1'b0, 32'h7, 32'h7, 32'hA00, 32'h100, 1'b1, 32'hB00, 5'd14, 1'b1, 32'hB00, 1'b0);
        drain();

        // Stall: tags 1..3 with out_ready low, then drain one per cycle
        bus.out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 3; k++)
                    send(3'd0, 1'b0, 32'h9, 32'h9, 32'(k * 32'h1000), 32'h40, 1'b1,
                         32'(k * 32'h1000 + 32'h40), 5'(k), 1'b1, 32'(k * 32'h1000 + 32'h40), 1'b0);
            end
            begin
                wait_out(ok);
                chk("stall_out_valid_seen", 64'(ok), 64'd1);
                repeat (3) begin
                    @(negedge clock);
                    chk("stall_valid_hold", 64'(bus.out_valid), 64'd1);
                    chk("stall_tag_hold", 64'(bus.out_tag), 64'd1);
                    chk("stall_next_pc_hold", 64'(bus.out_next_pc), 64'h1040);
                end
                chk("stall_in_ready_low", 64'(bus.in_ready), 64'd0);
                @(posedge clock);
                #1;
                bus.out_ready = 1'b1;
                for (int k = 1; k <= 3; k++) begin
                    @(negedge clock);
                    chk("drain_valid", 64'(bus.out_valid), 64'd1);
                    chk("drain_tag", 64'(bus.out_tag), 64'(k));
                end
            end
        join
        drain();

        // Squash with two ops in flight plus a third presented
        bus.out_ready = 1'b0;
        send(3'd2, 1'b0, 32'h0, 32'h0, 32'hC00, 32'h10, 1'b1, 32'hC10, 5'd16, 1'b1, 32'hC10, 1'b0);
        send(3'd2, 1'b0, 32'h0, 32'h0, 32'hC04, 32'h10, 1'b1, 32'hC14, 5'd17, 1'b1, 32'hC14, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_tag   = 5'd18;
        bus.squash   = 1'b1;
        exp_q.delete();
        @(posedge clock);
        #1;
        bus.squash   = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("squash_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clock);
        #1;
        send(3'd1, 1'b0, 32'h3, 32'h4, 32'hD00, 32'h20, 1'b1, 32'hD20, 5'd19, 1'b1, 32'hD20, 1'b0);
        drain();
        repeat (4) @(negedge clock);
        @(posedge clock);
        #1;

        // Asynchronous reset while a result is stalled
        bus.out_ready = 1'b0;
        send(3'd0, 1'b0, 32'h1, 32'h1, 32'hE00, 32'h8, 1'b0, 32'h0, 5'd20, 1'b1, 32'hE08, 1'b1);
        wait_out(ok);
        chk("pre_reset_out_valid", 64'(ok), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_out_taken", 64'(bus.out_taken), 64'd0);
        chk("async_rst_out_next_pc", 64'(bus.out_next_pc), 64'd0);
        chk("async_rst_out_link", 64'(bus.out_link), 64'd0);
        chk("async_rst_out_mispredict", 64'(bus.out_mispredict), 64'd0);
        chk("async_rst_out_tag", 64'(bus.out_tag), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
`ifdef BRU_PERF_EN
        chk("perf_resolved_reset", 64'(perf_resolved), 64'd0);
        chk("perf_mispredict_reset", 64'(perf_mispredict), 64'd0);
`endif
        @(posedge clock);
        #1;
        bus.out_ready = 1'b1;
        send_perf_set();
        drain();
`ifdef BRU_PERF_EN
        chk("perf_resolved", 64'(perf_resolved), 64'd5);
        chk("perf_mispredict", 64'(perf_mispredict), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
